// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, flush, NOP bubbles and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter bit                SKID      = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID2 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // With the skid buffer, ready depends only on state, so it is effectively
  // registered and breaks the combinational ready path back upstream.
  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = (state != SKID2);
    end else begin : g_pass_ready
      assign in_ready = (state == EMPTY) | out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_q     <= NOP_VALUE;
      skid_q     <= NOP_VALUE;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (!out_valid && out_ready && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + CNT_ONE;

      if (flush) begin
        state  <= EMPTY;
        main_q <= NOP_VALUE;
        skid_q <= NOP_VALUE;
      end else begin
        unique case (state)
          EMPTY: begin
            if (in_fire) begin
              main_q <= in_data;
              state  <= FULL;
            end
          end
          FULL: begin
            if (in_fire && out_fire) begin
              main_q <= in_data;
            end else if (out_fire) begin
              main_q <= NOP_VALUE;
              state  <= EMPTY;
            end else if (in_fire && SKID) begin
              skid_q <= in_data;
              state  <= SKID2;
            end
          end
          SKID2: begin
            if (out_fire) begin
              main_q <= skid_q;
              skid_q <= NOP_VALUE;
              state  <= FULL;
            end
          end
          default: begin
            state  <= EMPTY;
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid and a no-skid instance share stimulus and
// are each compared every cycle against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP0 = 32'h0BAD_F00D;
  localparam logic [31:0] NOP1 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        rdy0, ov0, rdy1, ov1;
  logic [31:0] od0, od1;
  logic [3:0]  sc0, bc0;
  logic [15:0] sc1, bc1;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .NOP_VALUE(NOP0), .SKID(1'b1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .stall_cnt(sc0), .bubble_cnt(bc0)
  );

  pipe_stage_reg #(.DATA_W(32), .NOP_VALUE(NOP1), .SKID(1'b0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .stall_cnt(sc1), .bubble_cnt(bc1)
  );

  int total = 0;
  int bad   = 0;
  bit known = 1'b0;

  // Reference model: FIFO contents plus counters per instance.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          stc[2];
  int          buc[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_eval(input int idx, output logic rdy, output logic vld,
                                     output logic [31:0] dat);
    int sz;
    sz  = (idx == 0) ? q0.size() : q1.size();
    vld = (sz > 0);
    dat = (idx == 0) ? NOP0 : NOP1;
    if (sz > 0) dat = (idx == 0) ? q0[0] : q1[0];
    if (idx == 0) rdy = (sz < 2);
    else          rdy = (sz == 0) || out_ready;
  endfunction

  function automatic void model_edge(input int idx, input logic rdy, input logic vld);
    int  cmax;
    bit  inf, outf;
    cmax = (idx == 0) ? 15 : 65535;
    if (rst) begin
      if (idx == 0) q0.delete(); else q1.delete();
      stc[idx] = 0;
      buc[idx] = 0;
    end else begin
      inf  = in_valid && rdy;
      outf = vld && out_ready;
      if (vld && !out_ready && stc[idx] < cmax) stc[idx]++;
      if (!vld && out_ready && buc[idx] < cmax) buc[idx]++;
      if (flush) begin
        if (idx == 0) q0.delete(); else q1.delete();
      end else begin
        if (outf) begin
          if (idx == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (inf) begin
          if (idx == 0) q0.push_back(in_data); else q1.push_back(in_data);
        end
      end
    end
  endfunction

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy);
    logic        er[2];
    logic        ev[2];
    logic [31:0] ed[2];
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    for (int i = 0; i < 2; i++) model_eval(i, er[i], ev[i], ed[i]);
    if (known) begin
      check("skid.in_ready",    {63'd0, rdy0}, {63'd0, er[0]});
      check("skid.out_valid",   {63'd0, ov0},  {63'd0, ev[0]});
      check("skid.out_data",    {32'd0, od0},  {32'd0, ed[0]});
      check("skid.stall_cnt",   {60'd0, sc0},  64'(stc[0]));
      check("skid.bubble_cnt",  {60'd0, bc0},  64'(buc[0]));
      check("noskid.in_ready",  {63'd0, rdy1}, {63'd0, er[1]});
      check("noskid.out_valid", {63'd0, ov1},  {63'd0, ev[1]});
      check("noskid.out_data",  {32'd0, od1},  {32'd0, ed[1]});
      check("noskid.stall_cnt", {48'd0, sc1},  64'(stc[1]));
      check("noskid.bubble_cnt",{48'd0, bc1},  64'(buc[1]));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, er[i], ev[i]);
    if (r) known = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset with activity on the inputs
    step(1, 0, 1, 32'hDEAD, 0);
    step(1, 0, 1, 32'hDEAD, 1);
    step(0, 0, 0, 32'h0, 0);

    // Streaming 1..4 under continuous ready
    for (int unsigned k = 1; k <= 4; k++) step(0, 0, 1, 32'(k), 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    // Back-pressure: A,B,C offered while downstream stalls, then drain
    step(0, 0, 1, 32'hA, 1);
    step(0, 0, 1, 32'hB, 0);
    step(0, 0, 1, 32'hC, 0);
    step(0, 0, 1, 32'hC, 0);
    step(0, 0, 1, 32'hC, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 32'h0, 1);

    // Flush while the skid instance holds A,B and X is offered
    step(0, 0, 1, 32'hA, 1);
    step(0, 0, 1, 32'hB, 0);
    step(0, 1, 1, 32'h5555_AAAA, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    // Bubble: one entry followed by 3 idle cycles
    step(0, 0, 1, 32'hE, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 32'h0, 1);

    // Saturation of the 4-bit stall counter
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h1234, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 32'h0, 0);
    check("skid.stall_sat", {60'd0, sc0}, 64'd15);

    // Randomized traffic with occasional flush and reset
    for (int k = 0; k < 600; k++)
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 6));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the toy-cpu pipeline. It is the successor to the fixed-field ID/EX latch and is intended for any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- The stage payload is packed into one DATA_W vector. The register adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush and NOP bubble insertion.
- It provides saturating stall/bubble performance counters for pipeline profiling.

Parameters:
- DATA_W, 64, width of the packed stage payload (aluop, alusel, operands, we, waddr, delay-slot bits, link addr, ...).
- NOP_VALUE, {DATA_W{1'b0}}, payload value presented when the stage holds no instruction.
- SKID, 1, 1 selects the registered-ready 2-entry skid buffer; 0 selects a single entry with combinational ready.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all held and incoming entries (branch mispredict, exception).
- in_valid  input  1  upstream stage presents an instruction.
- in_ready  output  1  this register can accept an instruction this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  downstream sees a valid instruction.
- out_ready  input  1  downstream consumes this cycle (deasserted = downstream stall).
- out_data  output  DATA_W  payload to the downstream stage; equals NOP_VALUE whenever out_valid=0.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  output  CNT_W  cycles with out_valid=0 and out_ready=1.

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payload moves only on a fire.
- Reset (rst=1 at posedge):
  - State goes to EMPTY.
  - main and skid entries are set to NOP_VALUE.
  - out_valid=0, out_data=NOP_VALUE, stall_cnt=0, bubble_cnt=0.
  - in_ready=1 from the first cycle after reset.
  - rst overrides flush and all handshakes.
- States (SKID=1): EMPTY (no entry), FULL (main valid), SKID2 (main and skid valid).
  - EMPTY:
    - in_fire: main<=in_data, go to FULL.
    - Otherwise remain in EMPTY.
  - FULL:
    - in_fire and out_fire: main<=in_data, stay FULL.
    - out_fire only: main<=NOP_VALUE, go to EMPTY.
    - in_fire only: skid<=in_data, go to SKID2.
    - Neither: hold.
  - SKID2:
    - out_fire: main<=skid, skid<=NOP_VALUE, go to FULL.
    - Otherwise hold.
- in_ready (SKID=1): registered; in_ready = (state != SKID2). It never depends combinationally on out_ready.
- SKID=0:
  - Only EMPTY and FULL exist.
  - in_ready = (state==EMPTY) | out_ready, combinational.
  - FULL with in_fire and out_fire replaces main.
- out_valid = (state != EMPTY).
- out_data = main, which is NOP_VALUE in EMPTY.
- Latency and throughput:
  - One cycle from in_fire to out_valid.
  - Throughput of one entry per cycle under continuous ready.
  - Ordering is strictly FIFO; no entry is dropped or duplicated.
- Flush (rst=0, flush=1 at posedge):
  - State goes to EMPTY, main and skid are set to NOP_VALUE.
  - Any in_fire or out_fire in the same cycle still counts as a handshake. The in_data accepted in that cycle is discarded.
  - Counters are not cleared.
  - Flush while already in EMPTY has no effect.
- Downstream stall (out_ready=0): main is held unchanged; SKID=1 absorbs exactly one more entry, then in_ready drops.
- Upstream bubble (in_valid=0 while downstream consumes): the stage drains to EMPTY and presents NOP_VALUE with out_valid=0.
- Counters:
  - Updated each non-reset cycle per the port definitions.
  - Saturate at 2^CNT_W-1; no wrap-around.
  - Counted regardless of flush.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 and in_data=32'hDEAD -> out_valid=0, out_data=NOP_VALUE, both counters=0. in_ready=1 in the cycle after rst falls.
- Streaming: DATA_W=32, inputs 1,2,3,4 on consecutive cycles with out_ready=1 -> out_data 1,2,3,4 one cycle later each, no gaps, in_ready stays 1.
- Back-pressure (SKID=1):
  - Send A,B,C with out_ready=0 from the cycle A appears at the output -> in_ready drops after B is accepted and C is held upstream.
  - Raise out_ready -> output is A, B, C in order, stall_cnt equals the number of stalled cycles.
  - Repeat with SKID=0 -> in_ready follows out_ready combinationally; same ordering.
- Flush: in SKID2 holding A,B, assert flush with in_valid=1 and in_data=X -> next cycle state is EMPTY, out_valid=0, out_data=NOP_VALUE, in_ready=1. A, B and X are never seen downstream.
- Bubble: in_valid=0 for 3 cycles with out_ready=1 after one entry -> one valid output, then out_data=NOP_VALUE and bubble_cnt increments by 3.
- Saturation: CNT_W=4, hold out_ready=0 with the stage full for 20 cycles -> stall_cnt reaches 15 and stays at 15.
